vector_processor_controller: RTL and testbench
==============================================

// Module: vector_processor_controller
// PURPOSE
//  Sequencing FSM for the vector processor datapath. Accepts one instruction at a time from the scalar core via a valid/ready handshake.
//  Classifies it as CFG, ARITH, LOAD or STORE and drives the decode, CSR, regfile and operand-mux controls cycle by cycle.
//  Waits for the execute unit or memory unit to finish, then reports completion or error back to the scalar core.
// PARAMETERS
//  XLEN          32   scalar/instruction width
//  TIMEOUT_CYC   255  max cycles waiting on exe_done/mem_done before error (8-bit counter)
// PORTS
//  clk             in   1     clock, single domain
//  reset           in   1     synchronous, active-high
//  inst_valid      in   1     scalar core offers instruction
//  instruction     in   XLEN  offered instruction
//  inst_ready      out  1     controller can accept (IDLE only)
//  is_vec          in   1     decode legality flag for the latched instruction
//  inst_done       out  1     1-cycle pulse: instruction retired
//  inst_error      out  1     1-cycle pulse: illegal or timeout
//  exe_start       out  1     1-cycle pulse to execute unit
//  exe_done        in   1     execute result valid
//  mem_start       out  1     1-cycle pulse to load/store unit
//  mem_done        in   1     memory op complete
//  vl_sel, vtype_sel, lumop_sel, rs1rd_de, rs1_sel  out 1 each  decode controls
//  csrwr_en        out  1     CSR write strobe
//  vec_reg_wr_en, mask_operation, mask_wr_en        out 1 each  regfile controls
//  data_mux1_sel   out  2     00 vs1, 01 scalar1, 10 imm
//  data_mux2_sel   out  1     0 vs2, 1 scalar2
// BEHAVIOUR
//  - Reset (sync): state=IDLE, latched inst=0, counter=0; every output 0 except inst_ready=1.
//  - Accept when inst_valid&&inst_ready: latch instruction, go DECODE next cycle. inst_ready=1 only in IDLE.
//  - DECODE (1 cyc): is_vec=0 -> ERROR. Otherwise route by class:
//      CFG (op 1010111, f3 111) -> CSR; ARITH (op 1010111, f3!=111) -> EXEC;
//      LOAD (op 0000111) / STORE (op 0100111) -> MEM; any other opcode -> ERROR.
//  - CSR: csrwr_en=1 for one cycle, then DONE.
//  - EXEC: exe_start pulse on entry; wait for exe_done, then WB.
//  - MEM: mem_start pulse on entry; wait for mem_done. LOAD -> WB; STORE -> DONE.
//  - WB: vec_reg_wr_en=1 for one cycle, plus mask_wr_en if the op is a compare, then DONE.
//  - DONE: inst_done=1 for one cycle, then IDLE. ERROR: inst_error=1 for one cycle, then IDLE.
//  - Timeout: counter clears on entry to EXEC/MEM and increments each waiting cycle.
//      Counter reaching TIMEOUT_CYC without a done -> ERROR, with no write.
//      A done arriving in the same cycle as timeout wins (normal path).
//  - exe_done/mem_done outside EXEC/MEM are ignored. inst_valid outside IDLE is ignored; the core holds it.
//  - Reset mid-operation aborts: no done/error pulse, no writes.
//  - Decode controls are combinational from the latched instruction, held stable DECODE..DONE, and 0 in IDLE:
//      vl_sel=1 iff vsetivli (inst[31:30]=11).
//      vtype_sel=1 iff vsetvl (inst[31:25]=1000000), i.e. use rs2_data.
//      rs1rd_de=0 iff CFG && rs1==0 && rd!=0 (VLMAX); else 1.
//      rs1_sel=1 for LOAD/STORE.
//      lumop_sel=1 for LOAD with mop=00.
//      mask_operation = ~inst[25] (vm) for ARITH/LOAD/STORE.
//      mask_wr_en: compare ops only (funct6[5:3]=011).
//  - Operand muxes: f3 000/010 -> mux1=00; 100/110 -> 01; 011 -> 10.
//      data_mux2_sel=1 for strided LOAD/STORE (mop=10), else 0.
// CONFIGURATION
//  VEC_CTRL_PERF_EN defined:
//      adds outputs perf_retired[31:0] (+1 per inst_done) and perf_stall[31:0] (+1 per EXEC/MEM wait cycle).
//      Both counters clear on reset and wrap at 2^32.
//  VEC_CTRL_PERF_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  vec_ctrl_pkg holds:
//      ctrl_state_e {IDLE,DECODE,CSR,EXEC,MEM,WB,DONE,ERROR}
//      inst_class_e {CFG,ARITH,LOAD,STORE,BAD}
//      opcode and funct3 localparams, and the mux-select encodings.
//  Sub-module vec_ctrl_inst_classifier: purely combinational latched-inst -> class plus decode/mux control fields.
//  The top level holds the FSM, timeout counter and perf counters.
// TESTING
//  1. vsetvli x5,x6,e32m1 (0x0D0372D7), is_vec=1: csrwr_en high exactly 1 cycle, vtype_sel=0, rs1rd_de=1;
//     inst_done 3 cycles after accept.
//  2. vadd.vx v1,v2,x3 (0x0221C0D7), exe_done 4 cycles after exe_start: mux1=01;
//     vec_reg_wr_en 1 cycle after exe_done; then inst_done.
//  3. vmseq.vi v0,v2,5,v0.t (0x6022B057): mux1=10, mask_operation=1, mask_wr_en=1 in WB.
//  4. Strided load, mem_done never asserted: inst_error after 255 wait cycles; no vec_reg_wr_en; inst_ready back to 1.
//  5. is_vec=0 in DECODE -> inst_error next cycle. Also: reset asserted in EXEC -> IDLE, all outputs 0, no pulses.
//  6. Back-to-back: inst_valid held high -> second instruction accepted the cycle after inst_done.
//     With VEC_CTRL_PERF_EN: perf_retired=2.

Source files
------------

// File: rtl/vec_ctrl_pkg.sv
// Shared types and encodings for the vector processor controller.
// Optional perf counters in the top level are enabled by VEC_CTRL_PERF_EN.
package vec_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE, DECODE, CSR, EXEC, MEM, WB, DONE, ERROR
  } ctrl_state_e;

  typedef enum logic [2:0] {
    CFG, ARITH, LOAD, STORE, BAD
  } inst_class_e;

  localparam logic [6:0] OP_V     = 7'b1010111;
  localparam logic [6:0] OP_LOAD  = 7'b0000111;
  localparam logic [6:0] OP_STORE = 7'b0100111;

  localparam logic [2:0] F3_OPIVV = 3'b000;
  localparam logic [2:0] F3_OPMVV = 3'b010;
  localparam logic [2:0] F3_OPIVI = 3'b011;
  localparam logic [2:0] F3_OPIVX = 3'b100;
  localparam logic [2:0] F3_OPMVX = 3'b110;
  localparam logic [2:0] F3_OPCFG = 3'b111;

  localparam logic [1:0] MOP_UNIT    = 2'b00;
  localparam logic [1:0] MOP_STRIDED = 2'b10;

  localparam logic [1:0] MUX1_VS1    = 2'b00;
  localparam logic [1:0] MUX1_SCALAR = 2'b01;
  localparam logic [1:0] MUX1_IMM    = 2'b10;
  localparam logic       MUX2_VS2    = 1'b0;
  localparam logic       MUX2_SCALAR = 1'b1;

  // Operand-1 source implied by the OP* category in funct3.
  function automatic logic [1:0] mux1_for_funct3(input logic [2:0] f3);
    case (f3)
      F3_OPIVX, F3_OPMVX: return MUX1_SCALAR;
      F3_OPIVI:           return MUX1_IMM;
      default:            return MUX1_VS1;
    endcase
  endfunction

endpackage

// File: rtl/vec_ctrl_inst_classifier.sv
// Combinational decode of the latched instruction into its class and the
// decode / operand-mux control fields consumed by the controller.
module vec_ctrl_inst_classifier
  import vec_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] inst,
  output inst_class_e     inst_class,
  output logic            vl_sel,
  output logic            vtype_sel,
  output logic            rs1rd_de,
  output logic            rs1_sel,
  output logic            lumop_sel,
  output logic            mask_operation,
  output logic            is_compare,
  output logic [1:0]      data_mux1_sel,
  output logic            data_mux2_sel
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [1:0] mop;
  logic       vm;
  logic       is_mem;
  logic       unused_rs2;

  assign opcode     = inst[6:0];
  assign funct3     = inst[14:12];
  assign mop        = inst[27:26];
  assign vm         = inst[25];
  assign unused_rs2 = ^inst[24:20];

  always_comb begin
    inst_class = BAD;
    case (opcode)
      OP_V:     inst_class = (funct3 == F3_OPCFG) ? CFG : ARITH;
      OP_LOAD:  inst_class = LOAD;
      OP_STORE: inst_class = STORE;
      default:  inst_class = BAD;
    endcase
  end

  assign is_mem = (inst_class == LOAD) || (inst_class == STORE);

  assign vl_sel    = (inst_class == CFG) && (inst[31:30] == 2'b11);
  assign vtype_sel = (inst_class == CFG) && (inst[31:25] == 7'b1000000);
  // rs1=x0 with rd!=x0 on a config op requests VLMAX instead of rs1 data.
  assign rs1rd_de  = !((inst_class == CFG) && (inst[19:15] == 5'd0) && (inst[11:7] != 5'd0));
  assign rs1_sel   = is_mem;
  assign lumop_sel = (inst_class == LOAD) && (mop == MOP_UNIT);

  assign mask_operation = (is_mem || (inst_class == ARITH)) && !vm;
  assign is_compare     = (inst_class == ARITH) && (inst[31:29] == 3'b011);

  assign data_mux1_sel = (inst_class == ARITH) ? mux1_for_funct3(funct3) : MUX1_VS1;
  assign data_mux2_sel = (is_mem && (mop == MOP_STRIDED)) ? MUX2_SCALAR : MUX2_VS2;

endmodule

// File: rtl/vector_processor_controller.sv
// Sequencing FSM for the vector datapath: accept, decode, dispatch, wait, retire.
// Define VEC_CTRL_PERF_EN to add the perf_retired / perf_stall counters.
module vector_processor_controller
  import vec_ctrl_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inst_valid,
  input  logic [XLEN-1:0] instruction,
  output logic            inst_ready,
  input  logic            is_vec,
  output logic            inst_done,
  output logic            inst_error,
  output logic            exe_start,
  input  logic            exe_done,
  output logic            mem_start,
  input  logic            mem_done,
  output logic            vl_sel,
  output logic            vtype_sel,
  output logic            lumop_sel,
  output logic            rs1rd_de,
  output logic            rs1_sel,
  output logic            csrwr_en,
  output logic            vec_reg_wr_en,
  output logic            mask_operation,
  output logic            mask_wr_en,
  output logic [1:0]      data_mux1_sel,
  output logic            data_mux2_sel
`ifdef VEC_CTRL_PERF_EN
  ,
  output logic [31:0]     perf_retired,
  output logic [31:0]     perf_stall
`endif
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

  ctrl_state_e     state, next_state;
  logic [XLEN-1:0] inst_q;
  logic [7:0]      wait_cnt;
  logic            waiting, done_in, timed_out;

  inst_class_e dec_class;
  logic        dec_vl_sel, dec_vtype_sel, dec_rs1rd_de, dec_rs1_sel, dec_lumop_sel;
  logic        dec_mask_operation, dec_is_compare, dec_mux2_sel;
  logic [1:0]  dec_mux1_sel;

  vec_ctrl_inst_classifier #(.XLEN(XLEN)) u_classifier (
    .inst           (inst_q),
    .inst_class     (dec_class),
    .vl_sel         (dec_vl_sel),
    .vtype_sel      (dec_vtype_sel),
    .rs1rd_de       (dec_rs1rd_de),
    .rs1_sel        (dec_rs1_sel),
    .lumop_sel      (dec_lumop_sel),
    .mask_operation (dec_mask_operation),
    .is_compare     (dec_is_compare),
    .data_mux1_sel  (dec_mux1_sel),
    .data_mux2_sel  (dec_mux2_sel)
  );

  assign waiting   = (state == EXEC) || (state == MEM);
  assign done_in   = ((state == EXEC) && exe_done) || ((state == MEM) && mem_done);
  // A done in the final allowed wait cycle takes priority over the timeout.
  assign timed_out = waiting && !done_in && (wait_cnt == TIMEOUT_LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Counter sits at zero outside EXEC/MEM, so it is already clear on entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_q   <= '0;
      wait_cnt <= '0;
    end else begin
      if ((state == IDLE) && inst_valid) inst_q <= instruction;
      if (!waiting)      wait_cnt <= '0;
      else if (!done_in) wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (inst_valid) next_state = DECODE;
      DECODE: begin
        if (!is_vec) next_state = ERROR;
        else begin
          case (dec_class)
            CFG:         next_state = CSR;
            ARITH:       next_state = EXEC;
            LOAD, STORE: next_state = MEM;
            default:     next_state = ERROR;
          endcase
        end
      end
      CSR:  next_state = DONE;
      EXEC: begin
        if (exe_done)       next_state = WB;
        else if (timed_out) next_state = ERROR;
      end
      MEM: begin
        if (mem_done)       next_state = (dec_class == LOAD) ? WB : DONE;
        else if (timed_out) next_state = ERROR;
      end
      WB:      next_state = DONE;
      DONE:    next_state = IDLE;
      ERROR:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    inst_ready     = 1'b0;
    inst_done      = 1'b0;
    inst_error     = 1'b0;
    exe_start      = 1'b0;
    mem_start      = 1'b0;
    csrwr_en       = 1'b0;
    vec_reg_wr_en  = 1'b0;
    mask_wr_en     = 1'b0;
    vl_sel         = 1'b0;
    vtype_sel      = 1'b0;
    lumop_sel      = 1'b0;
    rs1rd_de       = 1'b0;
    rs1_sel        = 1'b0;
    mask_operation = 1'b0;
    data_mux1_sel  = MUX1_VS1;
    data_mux2_sel  = MUX2_VS2;
    case (state)
      IDLE:  inst_ready = 1'b1;
      CSR:   csrwr_en   = 1'b1;
      EXEC:  exe_start  = (wait_cnt == 8'd0);
      MEM:   mem_start  = (wait_cnt == 8'd0);
      WB: begin
        vec_reg_wr_en = 1'b1;
        mask_wr_en    = dec_is_compare;
      end
      DONE:    inst_done  = 1'b1;
      ERROR:   inst_error = 1'b1;
      default: ;
    endcase
    if (state != IDLE) begin
      vl_sel         = dec_vl_sel;
      vtype_sel      = dec_vtype_sel;
      lumop_sel      = dec_lumop_sel;
      rs1rd_de       = dec_rs1rd_de;
      rs1_sel        = dec_rs1_sel;
      mask_operation = dec_mask_operation;
      data_mux1_sel  = dec_mux1_sel;
      data_mux2_sel  = dec_mux2_sel;
    end
  end

`ifdef VEC_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_retired <= '0;
      perf_stall   <= '0;
    end else begin
      if (state == DONE)       perf_retired <= perf_retired + 32'd1;
      if (waiting && !done_in) perf_stall   <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vector_processor_controller.sv
// Self-checking bench for vector_processor_controller: directed vector table,
// hand-written reset/back-to-back sequences and randomized instructions vs a model.
module tb_vector_processor_controller;

  localparam int K_CFG = 0, K_ARITH = 1, K_LOAD = 2, K_STORE = 3, K_BAD = 4;
  localparam logic [16:0] ALL    = 17'h1FFFF;
  localparam logic [16:0] PULSES = 17'h1FE00;

  logic        clk = 1'b0;
  logic        reset, inst_valid, is_vec, exe_done, mem_done;
  logic [31:0] instruction;
  logic        inst_ready, inst_done, inst_error, exe_start, mem_start;
  logic        vl_sel, vtype_sel, lumop_sel, rs1rd_de, rs1_sel, csrwr_en;
  logic        vec_reg_wr_en, mask_operation, mask_wr_en, data_mux2_sel;
  logic [1:0]  data_mux1_sel;
`ifdef VEC_CTRL_PERF_EN
  logic [31:0] perf_retired, perf_stall;
`endif

  always #5 clk = ~clk;

  vector_processor_controller dut (
    .clk(clk), .reset(reset), .inst_valid(inst_valid), .instruction(instruction),
    .inst_ready(inst_ready), .is_vec(is_vec), .inst_done(inst_done), .inst_error(inst_error),
    .exe_start(exe_start), .exe_done(exe_done), .mem_start(mem_start), .mem_done(mem_done),
    .vl_sel(vl_sel), .vtype_sel(vtype_sel), .lumop_sel(lumop_sel), .rs1rd_de(rs1rd_de),
    .rs1_sel(rs1_sel), .csrwr_en(csrwr_en), .vec_reg_wr_en(vec_reg_wr_en),
    .mask_operation(mask_operation), .mask_wr_en(mask_wr_en),
    .data_mux1_sel(data_mux1_sel), .data_mux2_sel(data_mux2_sel)
`ifdef VEC_CTRL_PERF_EN
    , .perf_retired(perf_retired), .perf_stall(perf_stall)
`endif
  );

  logic [16:0] obs;
  assign obs = {inst_ready, inst_done, inst_error, exe_start, mem_start, csrwr_en,
                vec_reg_wr_en, mask_wr_en, vl_sel, vtype_sel, lumop_sel, rs1rd_de,
                rs1_sel, mask_operation, data_mux1_sel, data_mux2_sel};

  typedef struct {
    string       name;
    logic [31:0] inst;
    bit          isv;
    int          delay;
    int          cls;
    logic [8:0]  fields;
    bit          cmp;
  } vec_t;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_retired = 0;
  logic [31:0] exp_stall = 0;
  vec_t        tbl[12];

  // fields = {vl, vtype, lumop, rs1rd, rs1_sel, mask_op, mux1[1:0], mux2}
  function automatic logic [16:0] mkOut(bit rdy, bit dn, bit er, bit es, bit ms,
                                        bit csr, bit wr, bit mwr, logic [8:0] f);
    return {rdy, dn, er, es, ms, csr, wr, mwr, f};
  endfunction

  function automatic void model(input logic [31:0] inst, output int cls,
                                output logic [8:0] f, output bit cmp);
    logic [2:0] f3;
    logic [1:0] mop, mux1;
    bit         mem;
    f3  = inst[14:12];
    mop = inst[27:26];
    if (inst[6:0] == 7'b1010111)      cls = (f3 == 3'd7) ? K_CFG : K_ARITH;
    else if (inst[6:0] == 7'b0000111) cls = K_LOAD;
    else if (inst[6:0] == 7'b0100111) cls = K_STORE;
    else                              cls = K_BAD;
    mem  = (cls == K_LOAD) || (cls == K_STORE);
    mux1 = 2'b00;
    if (cls == K_ARITH) begin
      if (f3 == 3'd4 || f3 == 3'd6) mux1 = 2'b01;
      else if (f3 == 3'd3)          mux1 = 2'b10;
    end
    f[8]   = (cls == K_CFG) && inst[31] && inst[30];
    f[7]   = (cls == K_CFG) && (inst[31:25] == 7'h40);
    f[6]   = (cls == K_LOAD) && (mop == 2'd0);
    f[5]   = !((cls == K_CFG) && (inst[19:15] == 0) && (inst[11:7] != 0));
    f[4]   = mem;
    f[3]   = (mem || cls == K_ARITH) && !inst[25];
    f[2:1] = mux1;
    f[0]   = mem && (mop == 2'd2);
    cmp    = (cls == K_ARITH) && (inst[31:29] == 3'b011);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic junk();
    exe_done = 1'($urandom_range(0, 1));
    mem_done = 1'($urandom_range(0, 1));
  endtask

  task automatic checkOutput(input string name, input logic [16:0] exp, input logic [16:0] mask);
    total++;
    if ((obs & mask) !== (exp & mask)) begin
      bad++;
      $display("[TB] FAIL %s: got %b want %b mask %b", name, obs, exp, mask);
    end
  endtask

`ifdef VEC_CTRL_PERF_EN
  task automatic checkPerf(input string name);
    total++;
    if (perf_retired !== exp_retired) begin
      bad++;
      $display("[TB] FAIL %s retired: got %0d want %0d", name, perf_retired, exp_retired);
    end
    total++;
    if (perf_stall !== exp_stall) begin
      bad++;
      $display("[TB] FAIL %s stall: got %0d want %0d", name, perf_stall, exp_stall);
    end
  endtask
`endif

  task automatic doReset();
    reset = 1'b1; inst_valid = 1'b0; instruction = '0; is_vec = 1'b0;
    exe_done = 1'b0; mem_done = 1'b0;
    step();
    @(negedge clk);
    checkOutput("reset", mkOut(1, 0, 0, 0, 0, 0, 0, 0, 9'd0), ALL);
    step();
    reset = 1'b0;
    exp_retired = 0;
    exp_stall   = 0;
  endtask

  task automatic idleCycles(input int n);
    inst_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      junk();
      @(negedge clk);
      checkOutput("idle", mkOut(1, 0, 0, 0, 0, 0, 0, 0, 9'd0), ALL);
      step();
    end
  endtask

  // delay: wait cycle index on which exe_done/mem_done is raised, -1 for never.
  task automatic applyStimulus(input string name, input logic [31:0] inst, input bit isv,
                               input int delay, input int cls, input logic [8:0] f,
                               input bit cmp, input bit keep_valid, input logic [31:0] next_inst);
    bit fin, ok;
    int k;
    inst_valid = 1'b1; instruction = inst; is_vec = isv;
    junk();
    @(negedge clk);
    checkOutput({name, ":accept"}, mkOut(1, 0, 0, 0, 0, 0, 0, 0, 9'd0), ALL);
    step();
    instruction = $urandom;
    junk();
    @(negedge clk);
    checkOutput({name, ":decode"}, mkOut(0, 0, 0, 0, 0, 0, 0, 0, f), ALL);
    step();
    if (!isv || cls == K_BAD) begin
      inst_valid = keep_valid; instruction = next_inst;
      junk();
      @(negedge clk);
      checkOutput({name, ":error"}, mkOut(0, 0, 1, 0, 0, 0, 0, 0, f), PULSES);
      step();
    end else if (cls == K_CFG) begin
      junk();
      @(negedge clk);
      checkOutput({name, ":csr"}, mkOut(0, 0, 0, 0, 0, 1, 0, 0, f), ALL);
      step();
      inst_valid = keep_valid; instruction = next_inst;
      @(negedge clk);
      checkOutput({name, ":done"}, mkOut(0, 1, 0, 0, 0, 0, 0, 0, f), ALL);
      step();
      exp_retired++;
    end else begin
      fin = 0; ok = 0; k = 0;
      while (!fin) begin
        if (cls == K_ARITH) begin
          exe_done = (k == delay);
          mem_done = 1'($urandom_range(0, 1));
        end else begin
          mem_done = (k == delay);
          exe_done = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        checkOutput({name, ":wait"},
                    mkOut(0, 0, 0, cls == K_ARITH && k == 0, cls != K_ARITH && k == 0, 0, 0, 0, f), ALL);
        if (k == delay) begin
          ok = 1; fin = 1;
        end else begin
          exp_stall++;
          if (k == 254) fin = 1;
        end
        step();
        k++;
      end
      exe_done = 1'b0; mem_done = 1'b0;
      if (!ok) begin
        inst_valid = keep_valid; instruction = next_inst;
        @(negedge clk);
        checkOutput({name, ":timeout"}, mkOut(0, 0, 1, 0, 0, 0, 0, 0, f), PULSES);
        step();
      end else begin
        if (cls != K_STORE) begin
          junk();
          @(negedge clk);
          checkOutput({name, ":wb"}, mkOut(0, 0, 0, 0, 0, 0, 1, cmp, f), ALL);
          step();
        end
        inst_valid = keep_valid; instruction = next_inst;
        junk();
        @(negedge clk);
        checkOutput({name, ":done"}, mkOut(0, 1, 0, 0, 0, 0, 0, 0, f), ALL);
        step();
        exp_retired++;
      end
    end
  endtask

  initial begin
    int          cls;
    logic [8:0]  f;
    bit          cmp;
    logic [31:0] r;

    tbl[0]  = '{"vsetvli",     32'h0D0372D7, 1, 0,   K_CFG,   9'b000100000, 0};
    tbl[1]  = '{"vadd_vx",     32'h0221C0D7, 1, 4,   K_ARITH, 9'b000100010, 0};
    tbl[2]  = '{"vmseq_vi",    32'h6022B057, 1, 2,   K_ARITH, 9'b000101100, 1};
    tbl[3]  = '{"vle32",       32'h0202E107, 1, 0,   K_LOAD,  9'b001110000, 0};
    tbl[4]  = '{"vse32_m",     32'h0005E427, 1, 3,   K_STORE, 9'b000111000, 0};
    tbl[5]  = '{"vsetivli",    32'hC08473D7, 1, 0,   K_CFG,   9'b100100000, 0};
    tbl[6]  = '{"vsetvli_max", 32'h0D0072D7, 1, 0,   K_CFG,   9'b000000000, 0};
    tbl[7]  = '{"vsetvl",      32'h807372D7, 1, 0,   K_CFG,   9'b010100000, 0};
    tbl[8]  = '{"bad_opcode",  32'h00000013, 1, 0,   K_BAD,   9'b000100000, 0};
    tbl[9]  = '{"not_vec",     32'h0221C0D7, 0, 0,   K_ARITH, 9'b000100010, 0};
    tbl[10] = '{"lds_timeout", 32'h0A356207, 1, -1,  K_LOAD,  9'b000110001, 0};
    tbl[11] = '{"lds_last",    32'h0A356207, 1, 254, K_LOAD,  9'b000110001, 0};

    doReset();
`ifdef VEC_CTRL_PERF_EN
    checkPerf("perf_reset");
`endif

    for (int i = 0; i < 12; i++) begin
      applyStimulus(tbl[i].name, tbl[i].inst, tbl[i].isv, tbl[i].delay, tbl[i].cls,
                    tbl[i].fields, tbl[i].cmp, 1'b0, 32'd0);
      idleCycles(1);
    end
`ifdef VEC_CTRL_PERF_EN
    checkPerf("perf_table");
`endif

    // Reset while waiting in EXEC aborts silently.
    inst_valid = 1'b1; instruction = 32'h0221C0D7; is_vec = 1'b1;
    exe_done = 1'b0; mem_done = 1'b0;
    @(negedge clk);
    checkOutput("rst:accept", mkOut(1, 0, 0, 0, 0, 0, 0, 0, 9'd0), ALL);
    step();
    inst_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst:decode", mkOut(0, 0, 0, 0, 0, 0, 0, 0, 9'b000100010), ALL);
    step();
    @(negedge clk);
    checkOutput("rst:exec", mkOut(0, 0, 0, 1, 0, 0, 0, 0, 9'b000100010), ALL);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_retired = 0;
    exp_stall   = 0;
    for (int i = 0; i < 4; i++) begin
      exe_done = 1'b1;
      @(negedge clk);
      checkOutput("rst:after", mkOut(1, 0, 0, 0, 0, 0, 0, 0, 9'd0), ALL);
      step();
    end
    exe_done = 1'b0;

    // Back-to-back with inst_valid held through DONE.
    doReset();
    applyStimulus("b2b_a", 32'h0D0372D7, 1, 0, K_CFG, 9'b000100000, 0, 1'b1, 32'h0221C0D7);
    applyStimulus("b2b_b", 32'h0221C0D7, 1, 1, K_ARITH, 9'b000100010, 0, 1'b0, 32'd0);
`ifdef VEC_CTRL_PERF_EN
    checkPerf("perf_b2b");
`endif

    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      case ($urandom_range(0, 3))
        0: r[6:0] = 7'b1010111;
        1: r[6:0] = 7'b0000111;
        2: r[6:0] = 7'b0100111;
        default: ;
      endcase
      model(r, cls, f, cmp);
      applyStimulus("rand", r, ($urandom_range(0, 9) != 0), int'($urandom_range(0, 5)),
                    cls, f, cmp, 1'b0, 32'd0);
      idleCycles(int'($urandom_range(0, 2)));
    end
`ifdef VEC_CTRL_PERF_EN
    checkPerf("perf_rand");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
